// File: rtl/nor_pwr_stim_chk_pkg.sv
// Shared types and helpers for the NOR power stimulus/check stage.
// Provides the sequencer state enum, counter width and the reference NOR model.
package nor_pwr_pkg;

    // Sequencer states: idle, "from" slot, "to" slot, finish pulse
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FROM = 2'd1,
        TO   = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam int          CNT_W      = 16;
    localparam logic [15:0] CNT_MAX    = 16'hFFFF;
    localparam int          NOR_MAX_IN = 4;

    // Reference cell behaviour; narrower vectors are zero-extended by the caller
    function automatic logic nor_ref(input logic [NOR_MAX_IN-1:0] vec);
        return ~|vec;
    endfunction

endpackage

// File: rtl/nor_pwr_stim_chk_sat_cnt.sv
// Saturating event counter with synchronous clear.
// Clear wins over enable; the count sticks at all-ones instead of wrapping.
module sat_cnt
    import nor_pwr_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, else increment unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/nor_pwr_stim_chk.sv
// Stimulus/check stage around an N-input NOR cell under power test.
// Walks every ordered (from,to) input transition, samples QN in the last
// cycle of each slot, counts functional mismatches and QN toggles.
// Optional build macro GLITCH_CHK_EN: also compares QN in every slot cycle
// except the first, counting at most one error per slot.
module nor_pwr_stim_chk
    import nor_pwr_pkg::*;
#(
    parameter int N_IN     = 3,
    parameter int HOLD_CYC = 4,
    parameter int REPEAT_W = 8
) (
    input  logic                CLK,
    input  logic                RSTB,
    input  logic                START,
    input  logic [REPEAT_W-1:0] REPEAT,
    output logic [N_IN-1:0]     IN_VEC,
    input  logic                QN_OBS,
    output logic                BUSY,
    output logic                DONE,
    output logic [CNT_W-1:0]    ERR_CNT,
    output logic [CNT_W-1:0]    TOG_CNT,
    output state_t              STATE_DBG
);

    localparam int                 PAIR_W    = 2 * N_IN;
    localparam int                 HOLD_W    = $clog2(HOLD_CYC);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [PAIR_W-1:0]  PAIR_MAX  = {PAIR_W{1'b1}};

    state_t              state_q,    state_d;
    logic [HOLD_W-1:0]   hold_q,     hold_d;
    logic [PAIR_W-1:0]   pair_q,     pair_d;
    logic [REPEAT_W-1:0] pass_q,     pass_d;
    logic [REPEAT_W-1:0] rep_q,      rep_d;
    logic [N_IN-1:0]     in_vec_q,   in_vec_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic                prev_q,     prev_d;
    logic                prev_vld_q, prev_vld_d;
`ifdef GLITCH_CHK_EN
    logic                slot_err_q, slot_err_d;
`endif

    logic              in_slot;
    logic              slot_last;
    logic              sample;
    logic              exp_qn;
    logic              mism;
    logic              start_acc;
    logic              err_evt;
    logic              tog_evt;
    logic [PAIR_W-1:0] pair_inc;

    // Slot timing, expected cell output and counter events
    always_comb begin
        in_slot   = (state_q == FROM) || (state_q == TO);
        slot_last = (hold_q == HOLD_LAST);
        sample    = in_slot && slot_last;
        exp_qn    = nor_ref(NOR_MAX_IN'(in_vec_q));
        mism      = (QN_OBS != exp_qn);
        start_acc = (state_q == IDLE) && START;
        pair_inc  = pair_q + PAIR_W'(1);
        tog_evt   = sample && prev_vld_q && (QN_OBS != prev_q);
`ifdef GLITCH_CHK_EN
        err_evt   = sample && (mism || slot_err_q);
`else
        err_evt   = sample && mism;
`endif
    end

`ifdef GLITCH_CHK_EN
    // Remember a mid-slot mismatch until the slot closes; first cycle is exempt
    always_comb begin
        slot_err_d = slot_err_q;
        if (!in_slot || slot_last) begin
            slot_err_d = 1'b0;
        end else if ((hold_q != '0) && mism) begin
            slot_err_d = 1'b1;
        end
    end
`endif

    // Sequencer next state: slot walk, pass wrap and registered outputs
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        pair_d     = pair_q;
        pass_d     = pass_q;
        rep_d      = rep_q;
        in_vec_d   = in_vec_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d    = FROM;
                    hold_d     = '0;
                    pair_d     = '0;
                    pass_d     = '0;
                    rep_d      = (REPEAT == '0) ? REPEAT_W'(1) : REPEAT;
                    in_vec_d   = '0;
                    busy_d     = 1'b1;
                    prev_vld_d = 1'b0;
                end
            end
            FROM: begin
                if (slot_last) begin
                    state_d  = TO;
                    hold_d   = '0;
                    in_vec_d = pair_q[N_IN-1:0];
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            TO: begin
                if (slot_last) begin
                    hold_d = '0;
                    if (pair_q != PAIR_MAX) begin
                        state_d  = FROM;
                        pair_d   = pair_inc;
                        in_vec_d = pair_inc[PAIR_W-1:N_IN];
                    end else if ((pass_q + REPEAT_W'(1)) == rep_q) begin
                        state_d  = FIN;
                        pair_d   = '0;
                        in_vec_d = '0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        state_d  = FROM;
                        pair_d   = '0;
                        pass_d   = pass_q + REPEAT_W'(1);
                        in_vec_d = '0;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // The previous sample carries across passes, never across runs
        if (sample) begin
            prev_d     = QN_OBS;
            prev_vld_d = 1'b1;
        end
    end

    // All sequencer and sampler state; reset aborts a run without DONE
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            pair_q     <= '0;
            pass_q     <= '0;
            rep_q      <= '0;
            in_vec_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            prev_q     <= 1'b0;
            prev_vld_q <= 1'b0;
`ifdef GLITCH_CHK_EN
            slot_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            pair_q     <= pair_d;
            pass_q     <= pass_d;
            rep_q      <= rep_d;
            in_vec_q   <= in_vec_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
`ifdef GLITCH_CHK_EN
            slot_err_q <= slot_err_d;
`endif
        end
    end

    sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk   (CLK),
        .rst_n (RSTB),
        .en    (err_evt),
        .clr   (start_acc),
        .cnt   (ERR_CNT)
    );

    sat_cnt #(.W(CNT_W)) u_tog_cnt (
        .clk   (CLK),
        .rst_n (RSTB),
        .en    (tog_evt),
        .clr   (start_acc),
        .cnt   (TOG_CNT)
    );

    assign IN_VEC    = in_vec_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_nor_pwr_stim_chk.sv
// Directed bench for nor_pwr_stim_chk at default parameters (N_IN=3, HOLD_CYC=4).
// The NOR cell is modelled in the bench, with stuck-at-0 and single-cycle
// inversion modes; expected counts are hand-computed for the 64-pair walk.
module tb_nor_pwr_stim_chk;
    import nor_pwr_pkg::*;

    logic        CLK;
    logic        RSTB;
    logic        START;
    logic [7:0]  REPEAT;
    logic [2:0]  IN_VEC;
    logic        QN_OBS;
    logic        BUSY;
    logic        DONE;
    logic [15:0] ERR_CNT;
    logic [15:0] TOG_CNT;
    state_t      STATE_DBG;

    logic        glitch;
    logic        stuck_en;

    logic        sc_en;
    logic        sc_clr;
    logic [3:0]  sc_cnt;

    int          vec_cnt;
    int          miscmp;
    logic [2:0]  vec_hist [1:1100];

    // Bench-side NOR cell
    assign QN_OBS = stuck_en ? 1'b0 : ((~|IN_VEC) ^ glitch);

    nor_pwr_stim_chk dut (
        .CLK       (CLK),
        .RSTB      (RSTB),
        .START     (START),
        .REPEAT    (REPEAT),
        .IN_VEC    (IN_VEC),
        .QN_OBS    (QN_OBS),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR_CNT   (ERR_CNT),
        .TOG_CNT   (TOG_CNT),
        .STATE_DBG (STATE_DBG)
    );

    // Narrow counter instance so saturation is reachable in a short run
    sat_cnt #(.W(4)) u_sat_small (
        .clk   (CLK),
        .rst_n (RSTB),
        .en    (sc_en),
        .clr   (sc_clr),
        .cnt   (sc_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Start a run and follow it cycle by cycle until DONE, an abort or the budget
    task automatic do_run(input int glitch_at, input int abort_at, input int restart_at,
                          input int rep_change_at, input bit start_hold,
                          output int busy_n, output int done_n);
        busy_n = 0;
        done_n = 0;
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1;
        for (int c = 1; c <= 3000; c++) begin
            glitch = (c == glitch_at);
            START  = start_hold || (c == restart_at);
            if (c == rep_change_at) REPEAT = 8'd9;
            if (c <= 1100) vec_hist[c] = IN_VEC;
            if (c == abort_at) begin
                RSTB = 1'b0;
                #1;
                glitch = 1'b0;
                return;
            end
            if (BUSY) busy_n++;
            if (DONE) begin
                done_n++;
                break;
            end
            @(posedge CLK);
            #1;
        end
        glitch = 1'b0;
    endtask

    task automatic test_reset();
        vec_cnt += 6;
        if (BUSY !== 1'b0) begin miscmp++; $display("FAIL reset_busy got %b want 0", BUSY); end
        if (DONE !== 1'b0) begin miscmp++; $display("FAIL reset_done got %b want 0", DONE); end
        if (IN_VEC !== 3'd0) begin miscmp++; $display("FAIL reset_in_vec got %0d want 0", IN_VEC); end
        if (ERR_CNT !== 16'd0) begin miscmp++; $display("FAIL reset_err got %0d want 0", ERR_CNT); end
        if (TOG_CNT !== 16'd0) begin miscmp++; $display("FAIL reset_tog got %0d want 0", TOG_CNT); end
        if (STATE_DBG !== IDLE) begin miscmp++; $display("FAIL reset_state got %0d want 0", STATE_DBG); end
    endtask

    task automatic test_single_pass();
        int busy_n, done_n;
        logic [5:0] pair;
        logic [2:0] exp_v;
        REPEAT = 8'd1;
        // A second START at cycle 200 must be ignored
        do_run(0, 0, 200, 0, 1'b0, busy_n, done_n);
        vec_cnt += 4;
        if (busy_n != 512) begin miscmp++; $display("FAIL single_busy got %0d want 512", busy_n); end
        if (done_n != 1) begin miscmp++; $display("FAIL single_done got %0d want 1", done_n); end
        if (ERR_CNT !== 16'd0) begin miscmp++; $display("FAIL single_err got %0d want 0", ERR_CNT); end
        if (TOG_CNT !== 16'd27) begin miscmp++; $display("FAIL single_tog got %0d want 27", TOG_CNT); end
        for (int k = 0; k < 128; k++) begin
            pair  = 6'(k / 2);
            exp_v = (k % 2 == 0) ? pair[5:3] : pair[2:0];
            vec_cnt++;
            if (vec_hist[1 + 4*k] !== exp_v || vec_hist[4 + 4*k] !== exp_v) begin
                miscmp++;
                $display("FAIL slot_vec slot %0d got %0d/%0d want %0d", k,
                         vec_hist[1 + 4*k], vec_hist[4 + 4*k], exp_v);
            end
        end
        @(posedge CLK);
        #1;
        vec_cnt += 2;
        if (DONE !== 1'b0) begin miscmp++; $display("FAIL done_width got %b want 0", DONE); end
        if (STATE_DBG !== IDLE) begin miscmp++; $display("FAIL after_fin_state got %0d want 0", STATE_DBG); end
        repeat (5) @(posedge CLK);
        #1;
        vec_cnt += 2;
        if (ERR_CNT !== 16'd0) begin miscmp++; $display("FAIL hold_err got %0d want 0", ERR_CNT); end
        if (TOG_CNT !== 16'd27) begin miscmp++; $display("FAIL hold_tog got %0d want 27", TOG_CNT); end
    endtask

    task automatic test_two_pass();
        int busy_n, done_n;
        REPEAT = 8'd2;
        // REPEAT moves to 9 mid-run; the latched value of 2 must stand
        do_run(0, 0, 0, 10, 1'b0, busy_n, done_n);
        vec_cnt += 4;
        if (busy_n != 1024) begin miscmp++; $display("FAIL two_busy got %0d want 1024", busy_n); end
        if (done_n != 1) begin miscmp++; $display("FAIL two_done got %0d want 1", done_n); end
        if (ERR_CNT !== 16'd0) begin miscmp++; $display("FAIL two_err got %0d want 0", ERR_CNT); end
        if (TOG_CNT !== 16'd55) begin miscmp++; $display("FAIL two_tog got %0d want 55", TOG_CNT); end
        REPEAT = 8'd1;
        repeat (2) @(posedge CLK);
    endtask

    task automatic test_stuck_low();
        int busy_n, done_n;
        stuck_en = 1'b1;
        do_run(0, 0, 0, 0, 1'b0, busy_n, done_n);
        stuck_en = 1'b0;
        vec_cnt += 3;
        if (busy_n != 512) begin miscmp++; $display("FAIL stuck_busy got %0d want 512", busy_n); end
        if (ERR_CNT !== 16'd16) begin miscmp++; $display("FAIL stuck_err got %0d want 16", ERR_CNT); end
        if (TOG_CNT !== 16'd0) begin miscmp++; $display("FAIL stuck_tog got %0d want 0", TOG_CNT); end
        repeat (2) @(posedge CLK);
    endtask

    task automatic test_abort();
        int busy_n, done_n;
        // Stuck output so counters are non-zero before the abort
        stuck_en = 1'b1;
        do_run(0, 100, 0, 0, 1'b0, busy_n, done_n);
        stuck_en = 1'b0;
        vec_cnt += 6;
        if (BUSY !== 1'b0) begin miscmp++; $display("FAIL abort_busy got %b want 0", BUSY); end
        if (IN_VEC !== 3'd0) begin miscmp++; $display("FAIL abort_in_vec got %0d want 0", IN_VEC); end
        if (ERR_CNT !== 16'd0) begin miscmp++; $display("FAIL abort_err got %0d want 0", ERR_CNT); end
        if (TOG_CNT !== 16'd0) begin miscmp++; $display("FAIL abort_tog got %0d want 0", TOG_CNT); end
        if (DONE !== 1'b0) begin miscmp++; $display("FAIL abort_done got %b want 0", DONE); end
        if (done_n != 0) begin miscmp++; $display("FAIL abort_done_seen got %0d want 0", done_n); end
        @(negedge CLK);
        RSTB = 1'b1;
        do_run(0, 0, 0, 0, 1'b0, busy_n, done_n);
        vec_cnt += 4;
        if (busy_n != 512) begin miscmp++; $display("FAIL rerun_busy got %0d want 512", busy_n); end
        if (done_n != 1) begin miscmp++; $display("FAIL rerun_done got %0d want 1", done_n); end
        if (ERR_CNT !== 16'd0) begin miscmp++; $display("FAIL rerun_err got %0d want 0", ERR_CNT); end
        if (TOG_CNT !== 16'd27) begin miscmp++; $display("FAIL rerun_tog got %0d want 27", TOG_CNT); end
        repeat (2) @(posedge CLK);
    endtask

    task automatic test_glitch();
        int busy_n, done_n;
        logic [15:0] exp_err;
`ifdef GLITCH_CHK_EN
        exp_err = 16'd1;
`else
        exp_err = 16'd0;
`endif
        // Slot 5 spans run cycles 21..24; invert QN in its second cycle only
        do_run(22, 0, 0, 0, 1'b0, busy_n, done_n);
        vec_cnt += 2;
        if (ERR_CNT !== exp_err) begin miscmp++; $display("FAIL glitch_err got %0d want %0d", ERR_CNT, exp_err); end
        if (TOG_CNT !== 16'd27) begin miscmp++; $display("FAIL glitch_tog got %0d want 27", TOG_CNT); end
        repeat (2) @(posedge CLK);
    endtask

    task automatic test_start_held();
        int busy_n, done_n;
        REPEAT = 8'd0;
        do_run(0, 0, 0, 0, 1'b1, busy_n, done_n);
        vec_cnt += 3;
        if (busy_n != 512) begin miscmp++; $display("FAIL held_busy got %0d want 512", busy_n); end
        if (done_n != 1) begin miscmp++; $display("FAIL held_done got %0d want 1", done_n); end
        if (TOG_CNT !== 16'd27) begin miscmp++; $display("FAIL held_tog got %0d want 27", TOG_CNT); end
        @(posedge CLK);
        #1;
        vec_cnt += 2;
        if (STATE_DBG !== IDLE) begin miscmp++; $display("FAIL held_idle got %0d want 0", STATE_DBG); end
        if (BUSY !== 1'b0) begin miscmp++; $display("FAIL held_idle_busy got %b want 0", BUSY); end
        @(posedge CLK);
        #1;
        vec_cnt += 3;
        if (BUSY !== 1'b1) begin miscmp++; $display("FAIL held_restart got %b want 1", BUSY); end
        if (TOG_CNT !== 16'd0) begin miscmp++; $display("FAIL held_clr_tog got %0d want 0", TOG_CNT); end
        if (STATE_DBG !== FROM) begin miscmp++; $display("FAIL held_state got %0d want 1", STATE_DBG); end
        START = 1'b0;
        RSTB  = 1'b0;
        @(negedge CLK);
        RSTB  = 1'b1;
        REPEAT = 8'd1;
    endtask

    task automatic test_saturation();
        @(negedge CLK);
        sc_clr = 1'b1;
        @(negedge CLK);
        sc_clr = 1'b0;
        sc_en  = 1'b1;
        repeat (20) @(negedge CLK);
        sc_en  = 1'b0;
        vec_cnt++;
        if (sc_cnt !== 4'hF) begin miscmp++; $display("FAIL sat_hold got %0d want 15", sc_cnt); end
        sc_clr = 1'b1;
        sc_en  = 1'b1;
        @(negedge CLK);
        sc_clr = 1'b0;
        vec_cnt++;
        if (sc_cnt !== 4'h0) begin miscmp++; $display("FAIL sat_clr got %0d want 0", sc_cnt); end
        repeat (3) @(negedge CLK);
        sc_en = 1'b0;
        vec_cnt++;
        if (sc_cnt !== 4'd3) begin miscmp++; $display("FAIL sat_count got %0d want 3", sc_cnt); end
    endtask

    initial begin
        vec_cnt  = 0;
        miscmp   = 0;
        RSTB     = 1'b0;
        START    = 1'b0;
        REPEAT   = 8'd1;
        glitch   = 1'b0;
        stuck_en = 1'b0;
        sc_en    = 1'b0;
        sc_clr   = 1'b0;
        repeat (3) @(negedge CLK);
        RSTB = 1'b1;
        @(posedge CLK);
        #1;
        test_reset();
        test_single_pass();
        test_two_pass();
        test_stuck_low();
        test_abort();
        test_glitch();
        test_start_held();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
